bcd_digit_counter: RTL
======================

Name: bcd_digit_counter

Overview:
- Synchronous multi-digit BCD up/down counter.
- Sits directly upstream of the BCD-to-Gray converter and supplies its 4-bit BCD digit inputs each cycle.
- Supports enable, direction, parallel load with digit validation, and a cascade carry/borrow output for chaining counters.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); total count width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i], digit 0 least significant.
- bcd_out  output  4*DIGITS  current registered count.
- tc  output  1  terminal count, combinational: en & (up_dn ? all digits 9 : all digits 0).
- load_err  output  1  registered; pulses for one cycle after a load containing any digit > 9.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: bcd_out = 0, load_err = 0. tc follows from its equation: 1 only if en=1 and up_dn=0.
- Priority per edge: reset > load > en > hold.
- Load:
  - Each digit of load_val is captured in the same edge; visible on bcd_out next cycle.
  - Any digit > 9 is stored as 0; other digits load normally.
  - load_err=1 for exactly the cycle following such a load, otherwise 0.
  - A load with en=1 performs no count step that cycle.
- Count up:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and carries into the next digit; ripple is resolved within one cycle.
  - All-9s wraps to all-0s.
- Count down:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - All-0s wraps to all-9s.
- Latency: one cycle from en/load sampled to updated bcd_out.
- Direction change: up_dn may change any cycle and takes effect on the next step; there is no pipeline state.
- Digit validity: bcd_out never holds a digit > 9 under any input sequence.
- en low: count holds; tc=0.
- reset asserted mid-count or coincident with load: count clears to 0 and load_err=0; load is ignored.
- Cascading: tc of stage N drives en of stage N+1 with a shared up_dn.

Optional Feature:
- Macro: BCD_COUNTER_GRAY_OUT_EN.
- When defined:
  - Adds output gray_out (4*DIGITS), a per-digit Gray code of the value being registered into bcd_out: g3=b3, gk=bk^bk+1.
  - gray_out is registered alongside bcd_out, so both are aligned with zero added latency.
  - Reset value of gray_out is 0.
- When undefined: the port and logic are absent, and the block feeds the external converter only.

Decomposition:
- Package bcd_pkg:
  - BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0.
  - Digit typedef bcd_digit_t.
  - Function bcd_valid(digit).
  - Function bin2gray4(digit) for the optional feature.
- Sub-module bcd_digit_cell: one digit register.
  - Inputs: step_in (carry/borrow in), up_dn, load, load digit.
  - Outputs: digit, step_out (digit at 9 going up or at 0 going down, gated by step_in), invalid flag.
- Top instantiates DIGITS cells in a generate loop.
- tc = step_out of the last cell.
- load_err = registered OR of invalid flags gated by load.

Test Plan:
- Reset then en=1, up_dn=1 for 100 cycles (DIGITS=2) -> bcd_out 00,01..09,10..99,00; tc=1 only in cycles where bcd_out=99.
- Load 8'h37 then en=1, up_dn=0 for 40 cycles -> 37,36..00,99,98..; tc=1 exactly while bcd_out=00 with en=1.
- Load 8'h5C with en=1 -> next cycle bcd_out=50, load_err=1 for one cycle then 0; no count step applied.
- Count up to 45, toggle up_dn each cycle with en=1 -> 46,45,46,45; no invalid digit ever appears.
- Assert reset at count 72 together with load=1, load_val=8'h11 -> bcd_out=00 and load_err=0 next cycle.
- With BCD_COUNTER_GRAY_OUT_EN defined, count 0..9 on digit 0 -> gray_out[3:0] = 0,1,3,2,6,7,5,4,C,D, aligned with bcd_out each cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit counter.
//
// Contents:
//   BCD_W      width of one BCD digit
//   BCD_MAX    largest legal digit value (9)
//   BCD_MIN    smallest legal digit value (0)
//   bcd_digit_t  one BCD digit
//   bcd_valid()  1 when a 4-bit value is a legal BCD digit
//   bin2gray4()  4-bit binary-reflected Gray code of a digit, used only when
//                BCD_COUNTER_GRAY_OUT_EN is defined

package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

  // g3 = b3, gk = bk ^ bk+1
  function automatic bcd_digit_t bin2gray4(input bcd_digit_t digit);
    return digit ^ (digit >> 1);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter: a single digit register with its own
// load, wrap and carry/borrow logic.
//
// Optional build macro: BCD_COUNTER_GRAY_OUT_EN adds the registered 'gray'
// output (Gray code of the digit, aligned with 'digit').
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, clears the digit to 0
//   step_in     carry (up) / borrow (down) from the lower decade; digit 0 gets en
//   up_dn       1 = count up, 0 = count down
//   load        parallel load strobe, overrides step_in
//   load_digit  digit to load; an illegal value (>9) is stored as 0
//   digit       registered digit value, always 0..9
//   step_out    step_in gated by the digit sitting at its wrap point
//   invalid     combinational: load_digit is not a legal BCD digit
//   gray        (optional) registered Gray code of digit

module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             step_out,
  output logic             invalid
`ifdef BCD_COUNTER_GRAY_OUT_EN
  ,
  output logic [BCD_W-1:0] gray
`endif
);

  bcd_digit_t digit_q, digit_d;
  logic       at_wrap;

  // The digit is at the point where the next step in this direction wraps.
  always_comb begin
    at_wrap = up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  end

  always_comb begin
    step_out = step_in & at_wrap;
    invalid  = ~bcd_valid(load_digit);
  end

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = invalid ? BCD_MIN : load_digit;
    end else if (step_in) begin
      if (up_dn) begin
        digit_d = at_wrap ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_wrap ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

`ifdef BCD_COUNTER_GRAY_OUT_EN
  bcd_digit_t gray_q;

  // Encode the next-state value so the Gray register lines up with digit_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= bin2gray4(digit_d);
    end
  end

  assign gray = gray_q;
`endif

endmodule

// File: rtl/bcd_digit_counter.sv
// Synchronous multi-digit BCD up/down counter with enable, parallel load
// (illegal digits load as 0 and flag load_err) and a terminal-count output
// suitable for cascading: tc of one stage drives en of the next, with
// up_dn shared between stages.
//
// Optional build macro: BCD_COUNTER_GRAY_OUT_EN adds gray_out, the per-digit
// Gray code of bcd_out, registered with it (same cycle alignment).
//
// Parameters:
//   DIGITS    number of BCD digits (1..8); count width is 4*DIGITS
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   en        count enable, one step per cycle
//   up_dn     1 = up, 0 = down
//   load      parallel load strobe (priority over en)
//   load_val  BCD value to load, digit 0 in bits [3:0]
//   bcd_out   registered count
//   tc        combinational terminal count: en & (up_dn ? all 9s : all 0s)
//   load_err  registered, high for the cycle after a load with a digit > 9
//   gray_out  (optional) registered per-digit Gray code of bcd_out

module bcd_digit_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  load_err
`ifdef BCD_COUNTER_GRAY_OUT_EN
  ,
  output logic [4*DIGITS-1:0]   gray_out
`endif
);

  // step[i] is the carry/borrow into digit i; step[0] is the enable itself,
  // so step[DIGITS] is high exactly when every digit is at its wrap point.
  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] invalid;
  logic              load_err_q;

  assign step[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .step_in    (step[i]),
      .up_dn      (up_dn),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .digit      (bcd_out[4*i +: 4]),
      .step_out   (step[i+1]),
      .invalid    (invalid[i])
`ifdef BCD_COUNTER_GRAY_OUT_EN
      ,
      .gray       (gray_out[4*i +: 4])
`endif
    );
  end

  assign tc = step[DIGITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load & (|invalid);
    end
  end

  assign load_err = load_err_q;

endmodule
